uart_bus_device: RTL and testbench
==================================

// Module: uart_bus_device
// PURPOSE
//  Memory-mapped UART peripheral on the CPU device bus, downstream of the MEM stage.
//  Serves Device_Read/Device_Write accesses for addresses >= 0x40000000 inside its window.
//  Provides 8N1 transmit and receive, status flags and an interrupt request line.
//  Read data is combinational so a load completes in the same MEM cycle.
// PARAMETERS
//  CLK_FREQ   100_000_000   clk frequency in Hz
//  BAUD       9600          line rate; DIV = CLK_FREQ/BAUD cycles per bit (integer divide, DIV >= 4)
//  BASE_ADDR  32'h40000018  word address of TXD; RXD = BASE+4, CON = BASE+8
// PORTS
//  clk         input   1   system clock, all state on rising edge
//  reset       input   1   asynchronous, active-low reset (0 = reset)
//  Read        input   1   device read strobe (Device_Read)
//  Write       input   1   device write strobe (Device_Write)
//  Address     input   32  bus address (MemBus_Address)
//  Write_data  input   32  store data (MemBus_Write_Data)
//  Read_data   output  32  load data (Device_Read_Data); 0 when not addressed
//  uart_rx     input   1   asynchronous serial input, idle high
//  uart_tx     output  1   serial output, idle high
//  irq         output  1   level interrupt request
// BEHAVIOUR
//  Reset: uart_tx=1, irq=0, all registers/flags 0, both FSMs IDLE, divider counters 0.
//  Reset is honoured at any time, including mid-frame; the frame is abandoned and no flag is set.
//  Registers: TXD [7:0] W; RXD [7:0] R; CON [0]tx_ie RW, [1]rx_ie RW, [2]tx_done R sticky,
//   [3]rx_valid R, [4]tx_busy R, [5]rx_overrun R sticky; unused bits read 0.
//  Decode: word match on Address[31:2]; Address[1:0] ignored; unmapped addresses: no effect, Read_data=0.
//  Read_data is combinational from Read & Address. Read side effects apply at the next rising edge:
//   read RXD clears rx_valid; read CON clears tx_done and rx_overrun.
//  Write CON updates only bits [1:0]. Write RXD has no effect.
//  Write TXD while tx_busy=0: latch Write_data[7:0]; tx_busy=1 from the next edge.
//  Write TXD while tx_busy=1: dropped silently; the current frame is unaffected.
//  TX FSM IDLE->START->DATA->STOP->IDLE; each bit holds DIV cycles; data is sent LSB first.
//   uart_tx is registered: it goes low on the edge that accepts the TXD write.
//   In STOP, uart_tx=1. After STOP's DIV-th cycle: tx_busy=0 and tx_done=1.
//   Frame = 10*DIV cycles. A new TXD write is accepted on the same edge tx_busy clears.
//  RX path: uart_rx passes through a 2-flop synchronizer (2-cycle latency) before the FSM.
//  RX FSM IDLE->START->DATA->STOP->IDLE.
//   IDLE: a synced 1->0 transition enters START.
//   START: wait DIV/2 cycles, then resample. If low, go to DATA; if high (glitch), return to IDLE.
//   DATA: sample 8 bits at DIV intervals, mid-bit, LSB first.
//   STOP: sample after DIV cycles. If high: RXD<=byte and rx_valid<=1.
//    If rx_valid was already 1, set rx_overrun and overwrite RXD.
//    If low (framing error): discard the byte; flags unchanged.
//   Return to IDLE after the stop sample; the next start is detected from the next falling edge.
//  Simultaneous set and clear of any flag on the same edge: set wins.
//  irq = (tx_ie & tx_done) | (rx_ie & rx_valid), registered; follows the flags with 1 cycle latency.
//  TX and RX are fully independent and may run concurrently.
// TESTING (CLK_FREQ=1000, BAUD=100 -> DIV=10)
//  T1 write TXD=0x55 -> uart_tx: 0 for 10 cycles, then 1,0,1,0,1,0,1,0 (10 cycles each), then 1;
//     tx_busy=1 for 100 cycles; tx_done=1 afterwards; reading CON returns 0x04, next read returns 0x00.
//  T2 write TXD=0x55, then TXD=0xFF at cycle 30 -> the 0x55 frame is unchanged; no second frame follows.
//  T3 drive an 8N1 frame carrying 0xA3 on uart_rx, with rx_ie=1 -> RXD reads 0xA3, CON[3]=1, irq=1;
//     after a read of RXD: rx_valid=0 and irq=0.
//  T4 send 0x11 then 0x22 without reading -> RXD=0x22, CON[5]=1; reading CON clears bit 5.
//  T5 3-cycle low glitch on uart_rx, then stop bit held low on a valid frame -> no rx_valid, RXD unchanged.
//  T6 assert reset at cycle 40 of a TX frame and an RX frame -> uart_tx=1 immediately, all CON bits 0, irq=0.

Source files
------------

// File: rtl/uart_bus_device.sv
// Memory-mapped 8N1 UART on the device bus: TXD/RXD/CON registers, tx and rx
// FSMs driven by down-counting bit timers, and a registered level interrupt.
module uart_bus_device #(
  parameter int unsigned CLK_FREQ  = 100_000_000,
  parameter int unsigned BAUD      = 9600,
  parameter logic [31:0] BASE_ADDR = 32'h4000_0018
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Read,
  input  logic        Write,
  input  logic [31:0] Address,
  input  logic [31:0] Write_data,
  output logic [31:0] Read_data,
  input  logic        uart_rx,
  output logic        uart_tx,
  output logic        irq
);

  localparam int unsigned DIV = CLK_FREQ / BAUD;
  localparam int unsigned CW  = $clog2(DIV);
  localparam logic [CW-1:0] CNT_BIT  = CW'(DIV - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(DIV / 2 - 1);
  localparam logic [29:0] TXD_W = BASE_ADDR[31:2];
  localparam logic [29:0] RXD_W = BASE_ADDR[31:2] + 30'd1;
  localparam logic [29:0] CON_W = BASE_ADDR[31:2] + 30'd2;

  typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} st_e;

  st_e           tx_st_q, rx_st_q;
  logic [CW-1:0] tx_cnt_q, rx_cnt_q;
  logic [2:0]    tx_bit_q, rx_bit_q;
  logic [7:0]    tx_shift_q, rx_shift_q;
  logic          tx_q;
  logic          rx_s1_q, rx_s2_q, rx_prev_q;
  logic [7:0]    rxd_q, rxd_d;
  logic [1:0]    ie_q, ie_d;
  logic          tx_done_q, tx_done_d;
  logic          rx_valid_q, rx_valid_d;
  logic          ovr_q, ovr_d;
  logic          irq_q;

  // Address[1:0] and the upper store bits are intentionally ignored.
  logic unused_bits;
  assign unused_bits = ^{Address[1:0], Write_data[31:8]};

  logic sel_txd, sel_rxd, sel_con;
  assign sel_txd = (Address[31:2] == TXD_W);
  assign sel_rxd = (Address[31:2] == RXD_W);
  assign sel_con = (Address[31:2] == CON_W);

  logic wr_txd, wr_con, rd_rxd, rd_con;
  assign wr_txd = Write & sel_txd;
  assign wr_con = Write & sel_con;
  assign rd_rxd = Read & sel_rxd;
  assign rd_con = Read & sel_con;

  logic tx_busy, tx_fin, tx_start, rx_fin_ok;
  assign tx_busy   = (tx_st_q != ST_IDLE);
  assign tx_fin    = (tx_st_q == ST_STOP) && (tx_cnt_q == '0);
  // A write landing on the final stop cycle starts the next frame back to back.
  assign tx_start  = wr_txd & (~tx_busy | tx_fin);
  assign rx_fin_ok = (rx_st_q == ST_STOP) && (rx_cnt_q == '0) && rx_s2_q;

  // Transmit FSM: start bit, 8 data bits LSB first, stop bit, DIV cycles each.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_st_q    <= ST_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      tx_q       <= 1'b1;
    end else begin
      case (tx_st_q)
        ST_IDLE: begin
          if (tx_start) begin
            tx_st_q    <= ST_START;
            tx_cnt_q   <= CNT_BIT;
            tx_shift_q <= Write_data[7:0];
            tx_q       <= 1'b0;
          end
        end
        ST_START: begin
          if (tx_cnt_q == '0) begin
            tx_st_q    <= ST_DATA;
            tx_cnt_q   <= CNT_BIT;
            tx_bit_q   <= '0;
            tx_q       <= tx_shift_q[0];
            tx_shift_q <= {1'b0, tx_shift_q[7:1]};
          end else begin
            tx_cnt_q <= tx_cnt_q - 1'b1;
          end
        end
        ST_DATA: begin
          if (tx_cnt_q == '0) begin
            tx_cnt_q <= CNT_BIT;
            if (tx_bit_q == 3'd7) begin
              tx_st_q <= ST_STOP;
              tx_q    <= 1'b1;
            end else begin
              tx_bit_q   <= tx_bit_q + 1'b1;
              tx_q       <= tx_shift_q[0];
              tx_shift_q <= {1'b0, tx_shift_q[7:1]};
            end
          end else begin
            tx_cnt_q <= tx_cnt_q - 1'b1;
          end
        end
        ST_STOP: begin
          if (tx_cnt_q == '0) begin
            if (tx_start) begin
              tx_st_q    <= ST_START;
              tx_cnt_q   <= CNT_BIT;
              tx_shift_q <= Write_data[7:0];
              tx_q       <= 1'b0;
            end else begin
              tx_st_q <= ST_IDLE;
            end
          end else begin
            tx_cnt_q <= tx_cnt_q - 1'b1;
          end
        end
        default: tx_st_q <= ST_IDLE;
      endcase
    end
  end

  // Two-flop synchronizer plus a delayed copy for falling-edge detection.
  // Held at the idle-high level in reset so release never looks like a start bit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_s1_q   <= 1'b1;
      rx_s2_q   <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_s1_q   <= uart_rx;
      rx_s2_q   <= rx_s1_q;
      rx_prev_q <= rx_s2_q;
    end
  end

  // Receive FSM: confirm start at mid-bit, then sample each bit at its centre.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_st_q    <= ST_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
    end else begin
      case (rx_st_q)
        ST_IDLE: begin
          if (rx_prev_q && !rx_s2_q) begin
            rx_st_q  <= ST_START;
            rx_cnt_q <= CNT_HALF;
          end
        end
        ST_START: begin
          if (rx_cnt_q == '0) begin
            rx_cnt_q <= CNT_BIT;
            rx_bit_q <= '0;
            rx_st_q  <= rx_s2_q ? ST_IDLE : ST_DATA;
          end else begin
            rx_cnt_q <= rx_cnt_q - 1'b1;
          end
        end
        ST_DATA: begin
          if (rx_cnt_q == '0) begin
            rx_cnt_q   <= CNT_BIT;
            rx_shift_q <= {rx_s2_q, rx_shift_q[7:1]};
            if (rx_bit_q == 3'd7) rx_st_q <= ST_STOP;
            else                  rx_bit_q <= rx_bit_q + 1'b1;
          end else begin
            rx_cnt_q <= rx_cnt_q - 1'b1;
          end
        end
        ST_STOP: begin
          if (rx_cnt_q == '0) rx_st_q  <= ST_IDLE;
          else                rx_cnt_q <= rx_cnt_q - 1'b1;
        end
        default: rx_st_q <= ST_IDLE;
      endcase
    end
  end

  // Flag next-state: read clears apply first so a same-edge set wins.
  always_comb begin
    ie_d       = ie_q;
    rxd_d      = rxd_q;
    tx_done_d  = tx_done_q;
    rx_valid_d = rx_valid_q;
    ovr_d      = ovr_q;
    if (wr_con) ie_d = Write_data[1:0];
    if (rd_con) begin
      tx_done_d = 1'b0;
      ovr_d     = 1'b0;
    end
    if (rd_rxd) rx_valid_d = 1'b0;
    if (tx_fin) tx_done_d = 1'b1;
    if (rx_fin_ok) begin
      rxd_d      = rx_shift_q;
      rx_valid_d = 1'b1;
      if (rx_valid_q) ovr_d = 1'b1;
    end
  end

  // Register file and interrupt, irq lagging the flags by one cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ie_q       <= '0;
      rxd_q      <= '0;
      tx_done_q  <= 1'b0;
      rx_valid_q <= 1'b0;
      ovr_q      <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      ie_q       <= ie_d;
      rxd_q      <= rxd_d;
      tx_done_q  <= tx_done_d;
      rx_valid_q <= rx_valid_d;
      ovr_q      <= ovr_d;
      irq_q      <= (ie_q[0] & tx_done_q) | (ie_q[1] & rx_valid_q);
    end
  end

  // Combinational load data so the access completes in the same bus cycle.
  always_comb begin
    Read_data = '0;
    if (Read) begin
      if (sel_rxd)      Read_data = {24'd0, rxd_q};
      else if (sel_con) Read_data = {26'd0, ovr_q, tx_busy, rx_valid_q, tx_done_q, ie_q};
    end
  end

  assign uart_tx = tx_q;
  assign irq     = irq_q;

endmodule

// File: tb/tb_uart_bus_device.sv
// Bench for uart_bus_device with DIV=10; expectations come from an 8N1 frame
// model and a register/flag model kept here.
module tb_uart_bus_device;
  localparam int DIV = 10;
  localparam logic [31:0] BASE = 32'h4000_0018;
  localparam logic [31:0] A_TXD = BASE;
  localparam logic [31:0] A_RXD = BASE + 32'd4;
  localparam logic [31:0] A_CON = BASE + 32'd8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rd = 1'b0, wr = 1'b0;
  logic [31:0] addr = '0, wdata = '0;
  logic [31:0] rdata;
  logic        rx = 1'b1;
  logic        tx, irq;

  int checks = 0;
  int errors = 0;

  bit         m_tx_ie, m_rx_ie, m_tx_done, m_rx_valid, m_ovr;
  logic [7:0] m_rxd;

  uart_bus_device #(.CLK_FREQ(1000), .BAUD(100), .BASE_ADDR(BASE)) dut (
    .clk(clk), .reset(rst_n), .Read(rd), .Write(wr), .Address(addr),
    .Write_data(wdata), .Read_data(rdata), .uart_rx(rx), .uart_tx(tx), .irq(irq)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] exp_con();
    return {26'd0, m_ovr, 1'b0, m_rx_valid, m_tx_done, m_rx_ie, m_tx_ie};
  endfunction

  function automatic logic exp_irq();
    return (m_tx_ie & m_tx_done) | (m_rx_ie & m_rx_valid);
  endfunction

  function automatic void model_reset();
    m_tx_ie = 0; m_rx_ie = 0; m_tx_done = 0; m_rx_valid = 0; m_ovr = 0; m_rxd = '0;
  endfunction

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk); wr = 1'b1; addr = a; wdata = d;
    @(negedge clk); wr = 1'b0;
    if (a[31:2] == A_CON[31:2]) begin m_tx_ie = d[0]; m_rx_ie = d[1]; end
  endtask

  // Idle two cycles so irq has caught up with the flags, then one read access.
  task automatic bus_read(input logic [31:0] a, input logic [31:0] exp, input string nm);
    @(negedge clk); @(negedge clk);
    checks++;
    if (irq !== exp_irq()) begin
      errors++; $display("FAIL %s irq: got %0b want %0b", nm, irq, exp_irq());
    end
    rd = 1'b1; addr = a; #1;
    checks++;
    if (rdata !== exp) begin
      errors++; $display("FAIL %s data: got %h want %h", nm, rdata, exp);
    end
    @(negedge clk); rd = 1'b0;
  endtask

  task automatic read_con(input logic [31:0] a, input string nm);
    bus_read(a, exp_con(), nm);
    m_tx_done = 0; m_ovr = 0;
  endtask

  task automatic read_rxd(input string nm);
    bus_read(A_RXD, {24'd0, m_rxd}, nm);
    m_rx_valid = 0;
  endtask

  task automatic start_tx(input logic [7:0] b);
    @(negedge clk); wr = 1'b1; addr = A_TXD; wdata = {24'hABCDEF, b};
    @(posedge clk);
  endtask

  // Compare 100 cycles of uart_tx against the 8N1 frame of b; optionally
  // inject a TXD write at cycle inj_at. Busy is probed mid-frame.
  task automatic check_tx_wave(input logic [7:0] b, input int inj_at, input logic [7:0] inj_d,
                               input string nm);
    logic [9:0] frame;
    int bad, first;
    logic busy_seen;
    frame = {1'b1, b, 1'b0};
    bad = 0; first = -1; busy_seen = 1'b0;
    for (int k = 0; k < 10 * DIV; k++) begin
      @(negedge clk);
      wr = 1'b0; rd = 1'b0;
      if (tx !== frame[k / DIV]) begin
        bad++;
        if (first < 0) first = k;
      end
      if (k == 50) begin
        rd = 1'b1; addr = A_CON; #1;
        busy_seen = rdata[4];
        m_tx_done = 0; m_ovr = 0;
      end
      if (k == inj_at) begin
        wr = 1'b1; addr = A_TXD; wdata = {24'd0, inj_d};
      end
    end
    m_tx_done = 1;
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL %s wave: %0d bad cycles, first at %0d, byte %h", nm, bad, first, b);
    end
    checks++;
    if (busy_seen !== 1'b1) begin
      errors++; $display("FAIL %s busy: got %0b want 1", nm, busy_seen);
    end
  endtask

  task automatic expect_line_idle(input int n, input string nm);
    int bad;
    bad = 0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk); wr = 1'b0; rd = 1'b0;
      if (tx !== 1'b1) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL %s idle: %0d cycles with tx low, want 0", nm, bad);
    end
  endtask

  task automatic rx_send(input logic [7:0] b, input bit stop_ok);
    logic [9:0] f;
    f = {stop_ok, b, 1'b0};
    for (int k = 0; k < 10 * DIV; k++) begin
      @(negedge clk); rx = f[k / DIV];
    end
    @(negedge clk); rx = 1'b1;
    if (stop_ok) begin
      if (m_rx_valid) m_ovr = 1;
      m_rxd = b; m_rx_valid = 1;
    end
  endtask

  task automatic test_reset();
    model_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (tx !== 1'b1 || irq !== 1'b0) begin
      errors++; $display("FAIL reset outs: tx %0b irq %0b want 1 0", tx, irq);
    end
    rst_n = 1'b1;
    read_con(A_CON, "reset_con");
    read_rxd("reset_rxd");
  endtask

  task automatic test_decode();
    bus_read(A_TXD, 32'd0, "txd_read_zero");
    bus_write(BASE + 32'd12, 32'h3);
    bus_read(BASE + 32'd12, 32'd0, "unmapped_read");
    bus_read(32'h4000_0000, 32'd0, "unmapped_low");
    read_con(A_CON, "unmapped_write_no_effect");
    bus_write(A_CON, 32'hFFFF_FFFF);
    read_con(A_CON + 32'd3, "con_low_bits_ignored");
    bus_write(A_RXD, 32'h5A);
    read_rxd("rxd_write_no_effect");
    @(negedge clk); rd = 1'b0; addr = A_CON; #1;
    checks++;
    if (rdata !== 32'd0) begin
      errors++; $display("FAIL no_read_zero: got %h want 0", rdata);
    end
    bus_write(A_CON, 32'h0);
  endtask

  task automatic test_tx();
    logic [7:0] b;
    for (int i = 0; i < 4; i++) begin
      b = (i == 0) ? 8'h55 : 8'($urandom);
      start_tx(b);
      check_tx_wave(b, -1, 8'h00, "tx_frame");
      expect_line_idle(3, "tx_after");
      read_con(A_CON, "tx_done_con");
      read_con(A_CON, "tx_done_cleared");
    end
  endtask

  task automatic test_tx_drop();
    start_tx(8'h55);
    check_tx_wave(8'h55, 30, 8'hFF, "tx_drop");
    expect_line_idle(4 * DIV, "tx_no_second");
    read_con(A_CON, "tx_drop_con");
  endtask

  task automatic test_back_to_back();
    logic [7:0] b1, b2;
    b1 = 8'($urandom); b2 = 8'($urandom);
    bus_write(A_CON, 32'h1);
    start_tx(b1);
    check_tx_wave(b1, 99, b2, "b2b_first");
    check_tx_wave(b2, -1, 8'h00, "b2b_second");
    expect_line_idle(3, "b2b_after");
    read_con(A_CON, "b2b_con_irq");
    bus_write(A_CON, 32'h0);
  endtask

  task automatic test_rx();
    bus_write(A_CON, 32'h2);
    rx_send(8'hA3, 1'b1);
    read_con(A_CON, "rx_con_valid");
    read_rxd("rx_data_a3");
    read_con(A_CON, "rx_valid_cleared");
    for (int i = 0; i < 3; i++) begin
      rx_send(8'($urandom), 1'b1);
      read_con(A_CON, "rx_rand_con");
      read_rxd("rx_rand_data");
    end
    bus_write(A_CON, 32'h0);
  endtask

  task automatic test_overrun();
    rx_send(8'h11, 1'b1);
    rx_send(8'h22, 1'b1);
    read_con(A_CON, "ovr_set");
    read_con(A_CON, "ovr_cleared");
    read_rxd("ovr_data_22");
  endtask

  task automatic test_glitch_framing();
    @(negedge clk); rx = 1'b0;
    repeat (3) @(negedge clk);
    rx = 1'b1;
    repeat (2 * DIV) @(negedge clk);
    read_con(A_CON, "glitch_con");
    rx_send(8'($urandom), 1'b0);
    repeat (2 * DIV) @(negedge clk);
    read_con(A_CON, "framing_con");
    read_rxd("framing_rxd_kept");
  endtask

  task automatic test_concurrent();
    logic [7:0] b1, b2;
    b1 = 8'($urandom); b2 = 8'($urandom);
    bus_write(A_CON, 32'h3);
    fork
      begin start_tx(b1); check_tx_wave(b1, -1, 8'h00, "conc_tx"); end
      rx_send(b2, 1'b1);
    join
    read_con(A_CON, "conc_con");
    read_rxd("conc_rxd");
    bus_write(A_CON, 32'h0);
  endtask

  task automatic test_reset_mid();
    logic [9:0] f;
    f = {1'b1, 8'hC6, 1'b0};
    bus_write(A_CON, 32'h3);
    @(negedge clk); wr = 1'b1; addr = A_TXD; wdata = 32'h5A; rx = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk); wr = 1'b0; rx = f[k / DIV];
    end
    #2 rst_n = 1'b0; rx = 1'b1;
    #1;
    model_reset();
    checks++;
    if (tx !== 1'b1 || irq !== 1'b0) begin
      errors++; $display("FAIL reset_mid outs: tx %0b irq %0b want 1 0", tx, irq);
    end
    rd = 1'b1; addr = A_CON; #1;
    checks++;
    if (rdata !== 32'd0) begin
      errors++; $display("FAIL reset_mid con: got %h want 0", rdata);
    end
    rd = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    expect_line_idle(12 * DIV, "reset_mid_tx");
    read_con(A_CON, "reset_mid_con_after");
    read_rxd("reset_mid_rxd_after");
  endtask

  initial begin
    model_reset();
    test_reset();
    test_decode();
    test_tx();
    test_tx_drop();
    test_back_to_back();
    test_rx();
    test_overrun();
    test_glitch_framing();
    test_concurrent();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
